// File: rtl/dram_bus_arbiter.sv
// Arbitrates the single-port data DRAM between the CPU data port and one external
// valid/ready requester, with fixed read latency and bounded CPU priority.
module dram_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int RD_LAT         = 1,
    parameter int MAX_CPU_GRANTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdin,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_valid,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_adr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ready,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] dram_adr,
    output logic              dram_we,
    output logic [DATA_W-1:0] dram_wdin,
    input  logic [DATA_W-1:0] dram_rd
);

    localparam int SW = $clog2(MAX_CPU_GRANTS + 1);

    typedef enum logic [1:0] {IDLE, CPU_RD, EXT_RD} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [ADDR_W-1:0] rd_adr_q, rd_adr_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              cpu_win, ext_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            streak_q <= streak_d;
        end
    end

    // Datapath holding registers carry no reset; they are only read after being loaded.
    always_ff @(posedge clk) begin
        rd_adr_q    <= rd_adr_d;
        ext_rdata_q <= ext_rdata_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        rd_adr_d    = rd_adr_q;
        ext_rdata_d = ext_rdata_q;
        cpu_win     = 1'b0;
        ext_win     = 1'b0;
        dram_adr    = cpu_adr;
        dram_we     = 1'b0;
        dram_wdin   = cpu_wdin;
        cpu_stall   = 1'b0;
        cpu_rdata   = '0;
        ext_ready   = 1'b0;
        ext_rvalid  = 1'b0;
        ext_rdata   = ext_rdata_q;

        case (state_q)
            IDLE: begin
                cpu_win = cpu_req && (!ext_valid || (streak_q < SW'(MAX_CPU_GRANTS)));
                ext_win = ext_valid && !cpu_win;
                if (cpu_win) begin
                    // A CPU win with ext_valid high implies streak < MAX, so no overflow.
                    if (ext_valid) streak_d = streak_q + 1'b1;
                    if (cpu_we) begin
                        dram_we = 1'b1;
                    end else begin
                        cpu_stall = 1'b1;
                        state_d   = CPU_RD;
                        cnt_d     = 2'(RD_LAT);
                        rd_adr_d  = cpu_adr;
                    end
                end else if (ext_win) begin
                    ext_ready = 1'b1;
                    dram_adr  = ext_adr;
                    dram_wdin = ext_wdata;
                    cpu_stall = cpu_req;
                    streak_d  = '0;
                    if (ext_we) begin
                        dram_we = 1'b1;
                    end else begin
                        state_d  = EXT_RD;
                        cnt_d    = 2'(RD_LAT);
                        rd_adr_d = ext_adr;
                    end
                end
            end
            CPU_RD: begin
                dram_adr = rd_adr_q;
                cnt_d    = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    cpu_rdata = dram_rd;
                    state_d   = IDLE;
                end else begin
                    cpu_stall = 1'b1;
                end
            end
            EXT_RD: begin
                dram_adr  = rd_adr_q;
                cnt_d     = cnt_q - 2'd1;
                cpu_stall = cpu_req;
                if (cnt_q == 2'd1) begin
                    ext_rvalid  = 1'b1;
                    ext_rdata   = dram_rd;
                    ext_rdata_d = dram_rd;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!ext_valid) streak_d = '0;

        // Reset abandons any access in flight: no handshake or data escapes this cycle.
        if (rst) begin
            dram_we     = 1'b0;
            cpu_stall   = 1'b0;
            cpu_rdata   = '0;
            ext_ready   = 1'b0;
            ext_rvalid  = 1'b0;
            ext_rdata   = ext_rdata_q;
            ext_rdata_d = ext_rdata_q;
        end
    end

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Bench for dram_bus_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the arbitration rules and DRAM contents.
module tb_dram_bus_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;
    localparam int MAXG   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wdin, cpu_rdata;
    logic          cpu_stall;
    logic          ext_valid, ext_we;
    logic [AW-1:0] ext_adr;
    logic [DW-1:0] ext_wdata;
    logic          ext_ready, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic [AW-1:0] dram_adr;
    logic          dram_we;
    logic [DW-1:0] dram_wdin, dram_rd;

    always #5 clk = ~clk;

    dram_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_CPU_GRANTS(MAXG)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdin(cpu_wdin),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_valid(ext_valid), .ext_we(ext_we), .ext_adr(ext_adr), .ext_wdata(ext_wdata),
        .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .dram_adr(dram_adr), .dram_we(dram_we), .dram_wdin(dram_wdin), .dram_rd(dram_rd)
    );

    // 16-word DRAM with RD_LAT-cycle registered read
    logic          mem_init;
    logic [DW-1:0] dram_mem [16];
    logic [DW-1:0] rd_pipe  [RD_LAT];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) dram_mem[i] <= DW'(32'hA000_0000 + i);
        end else if (dram_we) begin
            dram_mem[dram_adr[5:2]] <= dram_wdin;
        end
        rd_pipe[0] <= dram_mem[dram_adr[5:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign dram_rd = rd_pipe[RD_LAT-1];

    // Reference model: memory image, remaining read cycles, owner, contention streak
    logic [DW-1:0] mem_m [16];
    int            m_busy, m_streak;
    logic          m_owner_ext;
    logic [AW-1:0] m_radr;
    logic [DW-1:0] m_hold;
    logic          m_has_hold;

    logic          e_stall, e_ready, e_rvalid, e_we, e_adr_chk, e_cpu_win, e_ext_win;
    logic [DW-1:0] e_cpu_rdata, e_ext_rdata, e_wdin;
    logic [AW-1:0] e_adr;

    int checks, errors;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_out();
        e_stall = 1'b0; e_ready = 1'b0; e_rvalid = 1'b0; e_we = 1'b0;
        e_cpu_rdata = '0; e_ext_rdata = '0;
        e_adr = cpu_adr; e_wdin = cpu_wdin; e_adr_chk = !rst;
        e_cpu_win = 1'b0; e_ext_win = 1'b0;
        if (rst) begin
            e_adr_chk = 1'b0;
        end else if (m_busy > 0) begin
            e_adr = m_radr;
            if (m_busy == 1) begin
                if (!m_owner_ext) begin
                    e_cpu_rdata = mem_m[m_radr[5:2]];
                end else begin
                    e_rvalid    = 1'b1;
                    e_ext_rdata = mem_m[m_radr[5:2]];
                    e_stall     = cpu_req;
                end
            end else begin
                e_stall = m_owner_ext ? cpu_req : 1'b1;
            end
        end else begin
            e_cpu_win = cpu_req && (!ext_valid || m_streak < MAXG);
            e_ext_win = ext_valid && !e_cpu_win;
            if (e_cpu_win) begin
                e_we    = cpu_we;
                e_stall = !cpu_we;
            end else if (e_ext_win) begin
                e_ready = 1'b1;
                e_we    = ext_we;
                e_adr   = ext_adr;
                e_wdin  = ext_wdata;
                e_stall = cpu_req;
            end
        end
    endtask

    task automatic look();
        #1;
        model_out();
        chk("cpu_stall",  DW'(cpu_stall),  DW'(e_stall));
        chk("ext_ready",  DW'(ext_ready),  DW'(e_ready));
        chk("ext_rvalid", DW'(ext_rvalid), DW'(e_rvalid));
        chk("dram_we",    DW'(dram_we),    DW'(e_we));
        chk("cpu_rdata",  cpu_rdata,       e_cpu_rdata);
        if (e_adr_chk) chk("dram_adr", dram_adr, e_adr);
        if (e_we) chk("dram_wdin", dram_wdin, e_wdin);
        if (e_rvalid) chk("ext_rdata", ext_rdata, e_ext_rdata);
        else if (m_has_hold) chk("ext_rdata_hold", ext_rdata, m_hold);
    endtask

    task automatic tick();
        if (rst) begin
            m_busy   = 0;
            m_streak = 0;
        end else begin
            if (m_busy > 0) begin
                if (m_busy == 1 && m_owner_ext) begin
                    m_hold     = mem_m[m_radr[5:2]];
                    m_has_hold = 1'b1;
                end
                m_busy--;
            end else if (e_cpu_win) begin
                if (cpu_we) mem_m[cpu_adr[5:2]] = cpu_wdin;
                else begin m_busy = RD_LAT; m_owner_ext = 1'b0; m_radr = cpu_adr; end
            end else if (e_ext_win) begin
                if (ext_we) mem_m[ext_adr[5:2]] = ext_wdata;
                else begin m_busy = RD_LAT; m_owner_ext = 1'b1; m_radr = ext_adr; end
            end
            if (!ext_valid || e_ext_win) m_streak = 0;
            else if (e_cpu_win) m_streak = (m_streak + 1 > MAXG) ? MAXG : m_streak + 1;
        end
        @(negedge clk);
    endtask

    task automatic clr();
        cpu_req = 1'b0; cpu_we = 1'b0; ext_valid = 1'b0; ext_we = 1'b0;
    endtask

    logic cpu_done, ext_acc;

    initial begin
        checks = 0; errors = 0;
        m_busy = 0; m_streak = 0; m_owner_ext = 1'b0; m_radr = '0;
        m_hold = '0; m_has_hold = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = DW'(32'hA000_0000 + i);
        mem_init = 1'b1;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h4; cpu_wdin = 32'h1111_1111;
        ext_valid = 1'b1; ext_we = 1'b1; ext_adr = 32'h8; ext_wdata = 32'h2222_2222;

        // Reset with both requesters active: everything must stay quiet
        @(negedge clk);
        look();
        chk("rst_dram_we", DW'(dram_we), 32'd0);
        chk("rst_ext_ready", DW'(ext_ready), 32'd0);
        chk("rst_cpu_stall", DW'(cpu_stall), 32'd0);
        tick();
        look(); tick();
        rst = 1'b0; mem_init = 1'b0; clr();
        look();
        chk("idle_adr", dram_adr, 32'h4);
        tick();

        // 1: CPU store 0x10 <- DEADBEEF
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h10; cpu_wdin = 32'hDEAD_BEEF;
        look();
        chk("t1_we", DW'(dram_we), 32'd1);
        chk("t1_stall", DW'(cpu_stall), 32'd0);
        tick();
        clr(); look(); tick();

        // 2: CPU load 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
        look(); chk("t2_stall0", DW'(cpu_stall), 32'd1); tick();
        look();
        chk("t2_stall1", DW'(cpu_stall), 32'd0);
        chk("t2_rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick();
        clr(); look(); tick();

        // 3: ext read 0x20 contending with a CPU store every cycle
        ext_valid = 1'b1; ext_we = 1'b0; ext_adr = 32'h20;
        for (int i = 0; i < MAXG; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b1;
            cpu_adr = {26'b0, 4'(i), 2'b00}; cpu_wdin = $urandom;
            look();
            chk("t3_cpu_we", DW'(dram_we), 32'd1);
            chk("t3_no_ready", DW'(ext_ready), 32'd0);
            tick();
        end
        cpu_adr = 32'h14; cpu_wdin = $urandom;
        look();
        chk("t3_ready", DW'(ext_ready), 32'd1);
        chk("t3_stall", DW'(cpu_stall), 32'd1);
        tick();
        ext_valid = 1'b0;
        look();
        chk("t3_rvalid", DW'(ext_rvalid), 32'd1);
        chk("t3_rdata", ext_rdata, 32'hA000_0008);
        tick();
        look(); chk("t3_cpu_after", DW'(dram_we), 32'd1); tick();
        clr(); look(); tick();

        // 4: CPU load arrives while an ext read is in flight
        ext_valid = 1'b1; ext_we = 1'b0; ext_adr = 32'h20;
        look(); chk("t4_ready", DW'(ext_ready), 32'd1); tick();
        ext_valid = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h10;
        look(); chk("t4_stall_ext", DW'(cpu_stall), 32'd1); tick();
        look(); chk("t4_stall_grant", DW'(cpu_stall), 32'd1); tick();
        look(); chk("t4_rdata", cpu_rdata, 32'hDEAD_BEEF); tick();
        clr(); look(); tick();

        // 5: reset lands on the CPU read completion cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h14;
        look(); tick();
        rst = 1'b1;
        look();
        chk("t5_stall", DW'(cpu_stall), 32'd0);
        chk("t5_rvalid", DW'(ext_rvalid), 32'd0);
        chk("t5_we", DW'(dram_we), 32'd0);
        chk("t5_rdata", cpu_rdata, 32'd0);
        tick();
        rst = 1'b0; clr();
        look(); chk("t5_idle_rdata", cpu_rdata, 32'd0); tick();

        // 6: ext write 0x30, then CPU load 0x30
        ext_valid = 1'b1; ext_we = 1'b1; ext_adr = 32'h30; ext_wdata = 32'h1234_5678;
        look();
        chk("t6_ready", DW'(ext_ready), 32'd1);
        chk("t6_we", DW'(dram_we), 32'd1);
        tick();
        ext_valid = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h30;
        look(); tick();
        look(); chk("t6_rdata", cpu_rdata, 32'h1234_5678); tick();
        clr(); look(); tick();

        // Random traffic from both sides, obeying the hold-until-accepted rules
        for (int c = 0; c < 800; c++) begin
            look();
            cpu_done = cpu_req && !e_stall;
            ext_acc  = ext_valid && e_ready;
            tick();
            if (!cpu_req || cpu_done) begin
                cpu_req  = ($urandom_range(0, 9) < 7);
                cpu_we   = 1'($urandom_range(0, 1));
                cpu_adr  = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                cpu_wdin = $urandom;
            end
            if (!ext_valid || ext_acc) begin
                ext_valid = ($urandom_range(0, 9) < 5);
                ext_we    = 1'($urandom_range(0, 1));
                ext_adr   = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                ext_wdata = $urandom;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
